note_sequencer: RTL



---
 rtl/note_sequencer_if.sv | 37 +++
 rtl/note_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer_if.sv
// Control, pattern-write and status bundle for note_sequencer.
// master: register/control side (drives start/stop/writes, reads status).
// slave : the sequencer itself.
interface note_sequencer_if #(
    parameter int unsigned STEPS    = 8,
    parameter int unsigned PERIOD_W = 8,
    parameter int unsigned DUR_W    = 4
);
    localparam int unsigned ADDR_W = $clog2(STEPS);

    // Control and pattern write port
    logic                start;
    logic                stop;
    logic                loop_en;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [PERIOD_W-1:0] wr_period;
    logic [DUR_W-1:0]    wr_dur;

    // Tone counter drive and status
    logic [PERIOD_W-1:0] tone_max;
    logic                tone_restart;
    logic                gate;
    logic [ADDR_W-1:0]   step;
    logic                busy;
    logic                done;

    modport master (
        output start, stop, loop_en, wr_en, wr_addr, wr_period, wr_dur,
        input  tone_max, tone_restart, gate, step, busy, done
    );

    modport slave (
        input  start, stop, loop_en, wr_en, wr_addr, wr_period, wr_dur,
        output tone_max, tone_restart, gate, step, busy, done
    );
endinterface

// File: rtl/note_sequencer.sv
// Programmable note pattern player. Each entry holds a tone period and a
// duration in ticks (dur 0 marks end-of-pattern). Drives the tone counter's
// max value and a restart strobe at every note boundary.
// Optional build macro NOTE_SEQ_GAP_EN: gate drops during the last tick of
// every note so consecutive notes are articulated.
module note_sequencer #(
    parameter int unsigned STEPS    = 8,
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned PERIOD_W = 8,
    parameter int unsigned DUR_W    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    note_sequencer_if.slave sif
);
    localparam int unsigned ADDR_W = $clog2(STEPS);
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] STEP_LAST = ADDR_W'(STEPS - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StPlay} state_e;

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] period_mem_q [STEPS];
    logic [PERIOD_W-1:0] period_mem_d [STEPS];
    logic [DUR_W-1:0]    dur_mem_q [STEPS];
    logic [DUR_W-1:0]    dur_mem_d [STEPS];
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
    logic [ADDR_W-1:0]   step_q, step_d;
    logic [PERIOD_W-1:0] tone_max_q, tone_max_d;
    logic                tone_restart_q, tone_restart_d;
    logic                gate_q, gate_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [PERIOD_W-1:0] cur_period;
    logic [DUR_W-1:0]    cur_dur;
    logic                eop;

    assign cur_period = period_mem_q[step_q];
    assign cur_dur    = dur_mem_q[step_q];

    // Pattern writes land only while idle; a write alongside start is seen by the next LOAD.
    always_comb begin
        period_mem_d = period_mem_q;
        dur_mem_d    = dur_mem_q;
        if (state_q == StIdle && sif.wr_en) begin
            period_mem_d[sif.wr_addr] = sif.wr_period;
            dur_mem_d[sif.wr_addr]    = sif.wr_dur;
        end
    end

    // Pattern storage, cleared on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STEPS; i++) begin
                period_mem_q[i] <= '0;
                dur_mem_q[i]    <= '0;
            end
        end else begin
            period_mem_q <= period_mem_d;
            dur_mem_q    <= dur_mem_d;
        end
    end

    // Next-state and registered-output logic for the IDLE/LOAD/PLAY sequencer.
    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        tick_cnt_d     = tick_cnt_q;
        dur_cnt_d      = dur_cnt_q;
        tone_max_d     = tone_max_q;
        tone_restart_d = 1'b0;
        gate_d         = gate_q;
        done_d         = 1'b0;
        eop            = 1'b0;

        unique case (state_q)
            StIdle: begin
                gate_d = 1'b0;
                if (sif.start && !sif.stop) begin
                    state_d = StLoad;
                    step_d  = '0;
                end
            end
            StLoad: begin
                if (sif.stop) begin
                    state_d = StIdle;
                    gate_d  = 1'b0;
                end else if (cur_dur == '0) begin
                    eop = 1'b1;
                end else begin
                    tone_max_d     = cur_period;
                    tone_restart_d = 1'b1;
                    // Periods 0 and 1 are rests.
                    gate_d         = (cur_period >= PERIOD_W'(2));
                    dur_cnt_d      = cur_dur;
                    tick_cnt_d     = '0;
                    state_d        = StPlay;
                end
            end
            StPlay: begin
                if (sif.stop) begin
                    state_d = StIdle;
                    gate_d  = 1'b0;
                end else if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    dur_cnt_d  = dur_cnt_q - 1'b1;
                    if (dur_cnt_q == DUR_W'(1)) begin
                        if (step_q == STEP_LAST) begin
                            eop = 1'b1;
                        end else begin
                            step_d  = step_q + 1'b1;
                            state_d = StLoad;
                        end
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                gate_d  = 1'b0;
            end
        endcase

        // End of pattern: loop back unless the pattern is empty, otherwise finish.
        if (eop) begin
            if (sif.loop_en && step_q != '0) begin
                step_d  = '0;
                state_d = StLoad;
            end else begin
                state_d = StIdle;
                done_d  = 1'b1;
                gate_d  = 1'b0;
            end
        end

`ifdef NOTE_SEQ_GAP_EN
        // Silence the final tick of each note for articulation.
        if (state_d == StPlay && dur_cnt_d == DUR_W'(1)) begin
            gate_d = 1'b0;
        end
`else
        // Gate stays continuous across consecutive non-rest notes.
`endif

        busy_d = (state_d != StIdle);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            step_q         <= '0;
            tick_cnt_q     <= '0;
            dur_cnt_q      <= '0;
            tone_max_q     <= '0;
            tone_restart_q <= 1'b0;
            gate_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            tick_cnt_q     <= tick_cnt_d;
            dur_cnt_q      <= dur_cnt_d;
            tone_max_q     <= tone_max_d;
            tone_restart_q <= tone_restart_d;
            gate_q         <= gate_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign sif.tone_max     = tone_max_q;
    assign sif.tone_restart = tone_restart_q;
    assign sif.gate         = gate_q;
    assign sif.step         = step_q;
    assign sif.busy         = busy_q;
    assign sif.done         = done_q;
endmodule
